fifo_fwft_ctrl_wm: RTL and testbench

//  Parametrised pointer/flag controller for a first-word-fall-through FIFO.
//  - Next generation of the range-sensor FIFO controller.
//  - Adds an occupancy count, simultaneous read/write at full, synchronous flush,

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_ptr_ctr.sv | 20 ++
 rtl/fifo_fwft_ctrl_wm.sv | 111 +++++++++++
 tb/tb_fifo_fwft_ctrl_wm.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FWFT FIFO controller family.
package fifo_pkg;

   typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE, OP_RDWR} fifo_op_t;

   function automatic int unsigned fifo_depth(input int unsigned addr_width);
      return 2 ** addr_width;
   endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrapping address counter used for both the head and tail pointers.
module fifo_ptr_ctr #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rs,
   input  logic                  clr,
   input  logic                  inc,
   output logic [ADDR_WIDTH-1:0] ptr
);

   // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rs || clr)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/fifo_fwft_ctrl_wm.sv
// FWFT FIFO pointer/flag controller with occupancy count and sticky errors.
// Define FIFO_WATERMARK_EN to build the almost_full/almost_empty compares.
module fifo_fwft_ctrl_wm
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = 2 ** ADDR_WIDTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  rs,
   input  logic                  flush,
   input  logic                  rd,
   input  logic                  wr,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                DEPTH = int'(fifo_depth(ADDR_WIDTH));
   localparam logic [ADDR_WIDTH:0] D_CNT = (ADDR_WIDTH + 1)'(DEPTH);

   if (AF_LEVEL < 0 || AE_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_bad_level
      $error("fifo_fwft_ctrl_wm: watermark level outside 0..depth");
   end

   logic                rd_ok;
   logic                wr_ok;
   fifo_op_t            op;
   logic [ADDR_WIDTH:0] count_n;

   assign rd_ok = rd & ~empty;
   // A write at full is still accepted when a read frees the head slot on the same edge.
   assign wr_ok = wr & (~full | rd_ok);
   assign we    = wr_ok & ~flush & ~rs;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      op      = OP_NONE;
      count_n = count;
      case ({wr_ok, rd_ok})
         2'b01:   op = OP_READ;
         2'b10:   op = OP_WRITE;
         2'b11:   op = OP_RDWR;
         default: op = OP_NONE;
      endcase
      case (op)
         OP_READ:  count_n = count - 1'b1;
         OP_WRITE: count_n = count + 1'b1;
         default:  count_n = count;
      endcase
   end

   fifo_ptr_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
      .clk (clk),
      .rs  (rs),
      .clr (flush),
      .inc (rd_ok),
      .ptr (rd_addr)
   );

   fifo_ptr_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
      .clk (clk),
      .rs  (rs),
      .clr (flush),
      .inc (wr_ok),
      .ptr (wr_addr)
   );

   always_ff @(posedge clk) begin
      if (rs || flush) begin
         count     <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count     <= count_n;
         full      <= (count_n == D_CNT);
         empty     <= (count_n == '0);
         overflow  <= overflow  | (wr & ~wr_ok);
         underflow <= underflow | (rd & empty);
      end
   end

`ifdef FIFO_WATERMARK_EN
   localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH + 1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH + 1)'(AE_LEVEL);

   always_ff @(posedge clk) begin
      if (rs || flush) begin
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         almost_full  <= (count_n >= AF_CNT);
         almost_empty <= (count_n <= AE_CNT);
      end
   end
`else
   assign almost_full  = 1'b0;
   assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_fwft_ctrl_wm.sv
// Bench for fifo_fwft_ctrl_wm: directed vector table plus randomized run against a count model.
module tb_fifo_fwft_ctrl_wm;

   localparam int AW = 2;
   localparam int D  = 4;
   localparam int AF = 3;
   localparam int AE = 1;

   logic          clk = 1'b0;
   logic          rs = 1'b0, flush = 1'b0, rd = 1'b0, wr = 1'b0;
   logic          we;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [AW:0]   count;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;

   fifo_fwft_ctrl_wm #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk          (clk),
      .rs           (rs),
      .flush        (flush),
      .rd           (rd),
      .wr           (wr),
      .we           (we),
      .rd_addr      (rd_addr),
      .wr_addr      (wr_addr),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Expected flag vector {full, empty, almost_full, almost_empty, overflow, underflow}.
   function automatic logic [5:0] exp_flags(input int cnt, input logic ovf, input logic unf);
      logic af, ae;
`ifdef FIFO_WATERMARK_EN
      af = (cnt >= AF);
      ae = (cnt <= AE);
`else
      af = 1'b0;
      ae = 1'b0;
`endif
      return {cnt == D, cnt == 0, af, ae, ovf, unf};
   endfunction

   function automatic logic [5:0] dut_flags();
      return {full, empty, almost_full, almost_empty, overflow, underflow};
   endfunction

   typedef struct {
      logic rs, flush, rd, wr;
      logic exp_we;
      int   cnt;
      logic ovf, unf;
      int   ra, wa;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, f, rr, w, e, input int c,
                               input logic o, u, input int ra, wa);
      vec_t v;
      v.rs = r; v.flush = f; v.rd = rr; v.wr = w; v.exp_we = e;
      v.cnt = c; v.ovf = o; v.unf = u; v.ra = ra; v.wa = wa;
      return v;
   endfunction

   // Behavioural model: occupancy is total pushes minus total pops; pointers are totals mod D.
   int   m_wr_total, m_rd_total;
   logic m_ovf, m_unf;

   task automatic model_clear();
      m_wr_total = 0; m_rd_total = 0; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   task automatic step(input logic r, f, rr, w, input string tag);
      int   cnt;
      logic rd_ok, wr_ok;
      @(negedge clk);
      rs = r; flush = f; rd = rr; wr = w;
      #1;
      cnt   = m_wr_total - m_rd_total;
      rd_ok = rr && cnt > 0;
      wr_ok = w && (cnt < D || rd_ok);
      check({tag, " we"}, 32'(we), 32'(wr_ok && !f && !r));
      @(posedge clk);
      if (r || f) model_clear();
      else begin
         if (rr && cnt == 0) m_unf = 1'b1;
         if (w && !wr_ok)    m_ovf = 1'b1;
         if (rd_ok) m_rd_total++;
         if (wr_ok) m_wr_total++;
      end
      #1;
      cnt = m_wr_total - m_rd_total;
      check({tag, " count"}, 32'(count), 32'(cnt));
      check({tag, " flags"}, 32'(dut_flags()), 32'(exp_flags(cnt, m_ovf, m_unf)));
      check({tag, " ptrs"}, 32'({rd_addr, wr_addr}), 32'({2'(m_rd_total % D), 2'(m_wr_total % D)}));
   endtask

   initial begin
      //           rs flush rd wr  we cnt ovf unf ra wa
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // reset
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 1));  // four writes, wr_addr wraps
      tbl.push_back(mk(0, 0, 0, 1, 1, 2, 0, 0, 0, 2));
      tbl.push_back(mk(0, 0, 0, 1, 1, 3, 0, 0, 0, 3));
      tbl.push_back(mk(0, 0, 0, 1, 1, 4, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 4, 0, 0, 1, 1));  // rd+wr at full x3
      tbl.push_back(mk(0, 0, 1, 1, 1, 4, 0, 0, 2, 2));
      tbl.push_back(mk(0, 0, 1, 1, 1, 4, 0, 0, 3, 3));
      tbl.push_back(mk(0, 0, 0, 1, 0, 4, 1, 0, 3, 3));  // write at full dropped
      tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 3, 3));  // overflow held
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));  // flush
      tbl.push_back(mk(0, 0, 1, 1, 1, 1, 0, 1, 0, 1));  // rd+wr at empty
      tbl.push_back(mk(0, 0, 0, 1, 1, 2, 0, 1, 0, 2));
      tbl.push_back(mk(0, 0, 0, 1, 1, 3, 0, 1, 0, 3));
      tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0));  // flush beats wr at count 3
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));  // read at empty
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // reset clears underflow
      tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 1));  // watermark sweep 0->3->0
      tbl.push_back(mk(0, 0, 0, 1, 1, 2, 0, 0, 0, 2));
      tbl.push_back(mk(0, 0, 0, 1, 1, 3, 0, 0, 0, 3));
      tbl.push_back(mk(0, 0, 1, 0, 0, 2, 0, 0, 1, 3));
      tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 2, 3));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3, 3));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));  // reset beats wr

      foreach (tbl[i]) begin
         @(negedge clk);
         rs = tbl[i].rs; flush = tbl[i].flush; rd = tbl[i].rd; wr = tbl[i].wr;
         #1;
         check($sformatf("row%0d we", i), 32'(we), 32'(tbl[i].exp_we));
         @(posedge clk);
         #1;
         check($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].cnt));
         check($sformatf("row%0d flags", i), 32'(dut_flags()),
               32'(exp_flags(tbl[i].cnt, tbl[i].ovf, tbl[i].unf)));
         check($sformatf("row%0d ptrs", i), 32'({rd_addr, wr_addr}),
               32'({2'(tbl[i].ra), 2'(tbl[i].wa)}));
      end

      // Both sticky errors set together, then a single flush clears them.
      model_clear();
      step(1, 0, 0, 0, "seq rst");
      step(0, 0, 1, 0, "seq unf");
      for (int i = 0; i < D; i++) step(0, 0, 0, 1, "seq fill");
      step(0, 0, 0, 1, "seq ovf");
      step(0, 0, 0, 0, "seq hold");
      check("seq both errors", 32'({overflow, underflow}), 32'(2'b11));
      step(0, 1, 1, 1, "seq flush");
      check("seq errors cleared", 32'({overflow, underflow}), 32'(2'b00));

      // Randomized traffic with alternating fill-biased and drain-biased phases.
      for (int i = 0; i < 600; i++) begin
         int   wr_pct;
         logic r_rs, r_fl, r_rd, r_wr;
         wr_pct = ((i / 60) % 2 == 0) ? 75 : 30;
         r_rs = ($urandom_range(99) < 2);
         r_fl = ($urandom_range(99) < 3);
         r_wr = ($urandom_range(99) < wr_pct);
         r_rd = ($urandom_range(99) < 100 - wr_pct);
         step(r_rs, r_fl, r_rd, r_wr, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
